// File: rtl/gfx_rom_fetch_sequencer.sv
// rtl/gfx_rom_fetch_sequencer.sv - queued multi-bank tile ROM fetch engine with fixed word slots
module gfx_rom_fetch_sequencer #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32,
  parameter int BANK_BITS  = 1,
  parameter int SLOT_CYC   = 8,
  parameter int ACCESS_CYC = 3,
  parameter int LEN_W      = 2,
  parameter int QDEPTH     = 4
) (
  input  logic                          M24,
  input  logic                          RES,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [LEN_W-1:0]              req_len,
  output logic [ADDR_W-BANK_BITS-1:0]   ROM_ADDR,
  output logic                          ROM_CEn,
  output logic [(2**BANK_BITS)-1:0]     ROM_OEn,
  input  logic [DATA_W-1:0]             ROM_DATA,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_last,
  output logic                          busy
);

  localparam int NBANK = 2**BANK_BITS;
  localparam int IA_W  = ADDR_W - BANK_BITS;
  localparam int CNT_W = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam int PTR_W = $clog2(QDEPTH);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] FETCH        = 2'd1;
  localparam logic [1:0] CAPTURE_WAIT = 2'd2;

  if (SLOT_CYC < 2) begin : g_bad_slot
    $error("SLOT_CYC must be at least 2");
  end
  if (ACCESS_CYC < 1 || ACCESS_CYC >= SLOT_CYC) begin : g_bad_access
    $error("ACCESS_CYC must lie in 1..SLOT_CYC-1");
  end

  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [LEN_W-1:0]  q_len  [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_next;
  logic              seen;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  remaining;
  logic              push, pop, slot_end;
  logic [ADDR_W-1:0] head_addr;
  logic [BANK_BITS-1:0] head_bank;

  assign push      = req_valid & req_ready;
  assign slot_end  = (state == CAPTURE_WAIT) && (cnt == CNT_W'(SLOT_CYC - 1));
  // IDLE waits one registered cycle of non-empty before loading, so the first
  // address appears on the second edge after the accept.
  assign pop       = ((state == IDLE) && seen && (count != '0)) ||
                     (slot_end && (remaining == '0) && (count != '0));
  assign head_addr = q_addr[rd_ptr];
  assign head_bank = head_addr[ADDR_W-1 -: BANK_BITS];
  assign busy      = (count != '0) || (state != IDLE);

  // Occupancy after this edge's accept and pop.
  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Request storage; contents need no reset because count guards every read.
  always_ff @(posedge M24) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_len[wr_ptr]  <= req_len;
    end
  end

  // FIFO pointers, occupancy and the registered ready/non-empty flags.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
      seen      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      req_ready <= (count_next != (PTR_W+1)'(QDEPTH));
      seen      <= (count != '0);
    end
  end

  // Slot sequencer: loads a request, steps words inside the bank, captures data.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      ROM_ADDR  <= '0;
      ROM_CEn   <= 1'b1;
      ROM_OEn   <= '1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      if (pop) begin
        ROM_ADDR  <= head_addr[IA_W-1:0];
        ROM_OEn   <= ~(NBANK'(1) << head_bank);
        ROM_CEn   <= 1'b0;
        remaining <= q_len[rd_ptr];
        cnt       <= '0;
        state     <= FETCH;
      end else begin
        case (state)
          FETCH: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ACCESS_CYC - 1)) begin
              rsp_valid <= 1'b1;
              rsp_data  <= ROM_DATA;
              rsp_last  <= (remaining == '0);
              state     <= CAPTURE_WAIT;
            end
          end
          CAPTURE_WAIT: begin
            if (slot_end) begin
              cnt <= '0;
              if (remaining != '0) begin
                ROM_ADDR  <= ROM_ADDR + 1'b1;
                remaining <= remaining - 1'b1;
                state     <= FETCH;
              end else begin
                ROM_CEn <= 1'b1;
                ROM_OEn <= '1;
                state   <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gfx_rom_fetch_sequencer.sv
// tb/tb_gfx_rom_fetch_sequencer.sv - self-checking bench for gfx_rom_fetch_sequencer
module tb_gfx_rom_fetch_sequencer;

  logic        M24 = 1'b0;
  logic        RES;
  logic        req_valid;
  logic        req_ready;
  logic [18:0] req_addr;
  logic [1:0]  req_len;
  logic [17:0] ROM_ADDR;
  logic        ROM_CEn;
  logic [1:0]  ROM_OEn;
  logic [31:0] ROM_DATA;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [17:0] addr;
    logic [1:0]  oen;
  } exp_t;

  exp_t expq[$];
  int   rsp_cyc[$];

  gfx_rom_fetch_sequencer #(
    .ADDR_W(19), .DATA_W(32), .BANK_BITS(1), .SLOT_CYC(8),
    .ACCESS_CYC(3), .LEN_W(2), .QDEPTH(4)
  ) dut (
    .M24(M24), .RES(RES),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .ROM_ADDR(ROM_ADDR), .ROM_CEn(ROM_CEn), .ROM_OEn(ROM_OEn), .ROM_DATA(ROM_DATA),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy)
  );

  always #5 M24 = ~M24;

  always @(posedge M24) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic b, input logic [17:0] a);
    return 32'hA5A5_0001 + ({13'd0, b, a} * 32'h0001_0003);
  endfunction

  // ROM model: enabled bank returns its word, otherwise a filler pattern.
  assign ROM_DATA = ROM_CEn ? 32'hDEAD_BEEF : rom_word(ROM_OEn == 2'b01, ROM_ADDR);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] ev);
    total++;
    assert (obs === ev) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ev);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge M24);
    @(negedge M24);
  endtask

  task automatic model_add(input logic [18:0] a, input logic [1:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      exp_t e;
      e.addr = a[17:0] + 18'(k);
      e.data = rom_word(a[18], e.addr);
      e.last = (k == int'(l));
      e.oen  = a[18] ? 2'b01 : 2'b10;
      expq.push_back(e);
    end
  endtask

  task automatic push(input logic [18:0] a, input logic [1:0] l, output int waited);
    waited = 0;
    req_addr = a;
    req_len = l;
    req_valid = 1'b1;
    while (!req_ready && waited < 1000) begin
      step(1);
      waited++;
    end
    check("push_ready", req_ready, 1);
    @(posedge M24);
    model_add(a, l);
    @(negedge M24);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || expq.size() != 0) && n < 3000) begin
      step(1);
      n++;
    end
    check("idle_timeout", n < 3000, 1);
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < rsp_cyc.size(); i++)
      check(tag, rsp_cyc[i] - rsp_cyc[i-1], 8);
  endtask

  // Response scoreboard: every pulse must match the next expected word.
  always @(negedge M24) begin : mon
    exp_t e;
    if (RES === 1'b1 && rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = expq.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_last", rsp_last, e.last);
        check("rsp_rom_addr", ROM_ADDR, e.addr);
        check("rsp_rom_oen", ROM_OEn, e.oen);
        check("rsp_rom_cen", ROM_CEn, 0);
      end
    end
  end

  initial begin
    int w;
    int nwords;
    logic [18:0] ra;
    logic [1:0]  rl;
    RES = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;

    // Reset state
    step(3);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cen", ROM_CEn, 1);
    check("rst_oen", ROM_OEn, 2'b11);
    check("rst_addr", ROM_ADDR, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 0);
    RES = 1'b1;
    step(2);

    // Single fetch timing
    push(19'h00000, 2'd0, w);
    req_valid = 1'b0;
    check("single_busy_e0", busy, 1);
    step(1);
    check("single_cen_e1", ROM_CEn, 1);
    step(1);
    check("single_addr_e2", ROM_ADDR, 0);
    check("single_oen_e2", ROM_OEn, 2'b10);
    check("single_cen_e2", ROM_CEn, 0);
    step(2);
    check("single_no_rsp_e4", rsp_valid, 0);
    step(1);
    check("single_rsp_e5", rsp_valid, 1);
    check("single_data_e5", rsp_data, 32'hA5A5_0001);
    check("single_last_e5", rsp_last, 1);
    step(4);
    check("single_cen_e9", ROM_CEn, 0);
    step(1);
    check("single_cen_e10", ROM_CEn, 1);
    check("single_oen_e10", ROM_OEn, 2'b11);
    check("single_addr_hold", ROM_ADDR, 0);
    check("single_busy_e10", busy, 0);
    wait_idle();

    // Bank select burst
    rsp_cyc.delete();
    push(19'h4001C, 2'd3, w);
    req_valid = 1'b0;
    wait_idle();
    check("bank_rsp_count", rsp_cyc.size(), 4);
    check_gaps("bank_gap");

    // Wrap inside the bank
    rsp_cyc.delete();
    push(19'h3FFFE, 2'd3, w);
    req_valid = 1'b0;
    wait_idle();
    check("wrap_rsp_count", rsp_cyc.size(), 4);
    check_gaps("wrap_gap");

    // Back-to-back bursts and a full FIFO
    rsp_cyc.delete();
    push(19'($urandom), 2'd3, w);
    req_valid = 1'b0;
    nwords = 4;
    w = 0;
    while (ROM_CEn && w < 20) begin
      step(1);
      w++;
    end
    check("b2b_started", ROM_CEn, 0);
    for (int i = 0; i < 4; i++) begin
      rl = 2'($urandom);
      push(19'($urandom), rl, w);
      nwords += int'(rl) + 1;
    end
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    rl = 2'($urandom);
    push(19'($urandom), rl, w);
    nwords += int'(rl) + 1;
    req_valid = 1'b0;
    check("fifth_waited", w > 0, 1);
    wait_idle();
    check("b2b_rsp_count", rsp_cyc.size(), nwords);
    check_gaps("b2b_gap");

    // Random traffic
    for (int i = 0; i < 16; i++) begin
      ra = 19'($urandom);
      rl = 2'($urandom);
      push(ra, rl, w);
      req_valid = 1'b0;
      step($urandom_range(0, 20));
    end
    wait_idle();
    check("rand_idle_ready", req_ready, 1);

    // Reset in the middle of the second word
    push(19'($urandom), 2'd3, w);
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin
      step(1);
      w++;
    end
    check("mid_first_rsp", rsp_valid, 1);
    step(7);
    check("mid_cen_active", ROM_CEn, 0);
    #2 RES = 1'b0;
    #1;
    check("mid_rst_cen", ROM_CEn, 1);
    check("mid_rst_oen", ROM_OEn, 2'b11);
    check("mid_rst_addr", ROM_ADDR, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    expq.delete();
    step(3);
    #2 RES = 1'b1;
    step(20);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_cen", ROM_CEn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
